pb_cmd_ctrl: RTL and testbench
==============================

# pb_cmd_ctrl

Push-button command controller for the Segway operator button. It synchronizes and debounces the raw active-low button, measures press timing, and classifies each gesture as SHORT, LONG or DOUBLE. The result is presented to the power/mode sequencer as a single command through a valid/acknowledge handshake, with overrun detection. It replaces ad-hoc release-edge detection wherever timed button gestures are needed.

## Interface
- DB_CNT, 500000: consecutive stable cycles needed to accept a new debounced level (10 ms at 50 MHz)
- LONG_CNT, 50000000: held cycles that make a press LONG (1 s)
- DBL_WIN, 15000000: cycles after a short release in which a second press makes a DOUBLE (0.3 s)
- clk  input  1  system clock; all state changes on posedge
- rst_n  input  1  asynchronous active-low reset
- PB  input  1  raw button; 0 = pressed, 1 = idle; asynchronous to clk
- cmd_ack  input  1  consumer accepts the pending command
- pressed  output  1  debounced level, 1 = held
- cmd  output  2  01 SHORT, 10 LONG, 11 DOUBLE; holds the last value, 00 after reset
- cmd_vld  output  1  command pending
- overrun  output  1  sticky: an event was dropped while cmd_vld was high

## Operation
- Synchronizer: two flops, asynchronously preset to 1 on reset, so no press is seen at reset release.
- Debouncer:
  - Stable register preset to 1.
  - Counter clears whenever the synchronized value equals the stable register.
  - The counter increments while they differ. When it reaches DB_CNT-1 and they still differ, the stable register takes the new value on the next edge.
  - pressed = ~stable.
  - Press event = stable 1->0. Release event = stable 0->1.
- FSM states: IDLE, PRESS, HOLD, WAIT2, PRESS2. Reset state is IDLE. A shared timer is sized to cover max(LONG_CNT, DBL_WIN) and clears on every state change.
  - IDLE: on press, go to PRESS.
  - PRESS: the timer increments each cycle.
    - On release, go to WAIT2.
    - If timer == LONG_CNT-1 with no release, emit LONG and go to HOLD.
    - If release and the threshold occur in the same cycle, release wins.
  - HOLD: on release, go to IDLE. No further events while in HOLD.
  - WAIT2: the timer increments each cycle.
    - On press, go to PRESS2.
    - If timer == DBL_WIN-1 with no press, emit SHORT and go to IDLE.
    - If press and timeout occur in the same cycle, press wins.
  - PRESS2: on release, emit DOUBLE and go to IDLE. There is no long detection here; any hold length still gives DOUBLE.
- Command register:
  - Emitting an event when cmd_vld is 0: cmd is loaded and cmd_vld is set.
  - Emitting an event when cmd_vld is 1 and cmd_ack is 0: the event is dropped, cmd is unchanged, and overrun is set.
  - Emitting an event when cmd_vld is 1 and cmd_ack is 1 in the same cycle: the new cmd is loaded, cmd_vld stays 1, and there is no overrun.
  - cmd_ack with cmd_vld high and no new event: cmd_vld clears on the next edge.
  - cmd_ack while cmd_vld is 0 is ignored.
- overrun clears only on reset.

## Timing
- Reset values:
  - pressed=0, cmd=00, cmd_vld=0, overrun=0.
  - Synchronizer flops and stable register = 1; FSM in IDLE; counters = 0.
- Reset mid-operation: everything returns to reset values immediately, and any pending command is lost.
- PB edge to pressed change:
  - The synchronized value changes on the 2nd clock edge after the PB edge.
  - The stable register changes DB_CNT edges after that, for a total of 2+DB_CNT edges.
- Any bounce back to the stable level restarts the debounce count.
- LONG: cmd_vld rises LONG_CNT edges after the FSM enters PRESS, while the button is still held.
- SHORT: cmd_vld rises DBL_WIN edges after the FSM enters WAIT2.
- DOUBLE: cmd_vld rises on the edge the FSM leaves PRESS2.
- Handshake: cmd_vld may stay high indefinitely; there is no timeout. A command is consumed on an edge where cmd_vld and cmd_ack are both 1.

## Test plan
Use DB_CNT=4, LONG_CNT=20 and DBL_WIN=10 for all scenarios.
- Reset with PB=1, then hold PB idle for 100 cycles -> pressed=0, cmd_vld=0, cmd=00, overrun=0 throughout.
- PB low for 3 cycles, then high (glitch) -> pressed never rises and no command is produced.
- PB low for 12 cycles, then high and idle -> pressed high, then low; 10 cycles after WAIT2 entry, cmd=01 and cmd_vld=1. Pulse cmd_ack for one cycle -> cmd_vld=0 on the next cycle.
- PB held low for 40 cycles -> cmd=10 and cmd_vld=1 exactly 20 cycles after pressed rises. Releasing afterwards produces no further event.
- Two 8-cycle presses separated by 6 idle cycles -> a single cmd=11 on the second release, with no SHORT emitted.
- Leave a SHORT unacknowledged, then perform a LONG -> cmd stays 01 and overrun=1. Repeat with cmd_ack high on the LONG emit cycle -> cmd=10, cmd_vld=1, overrun unchanged. Assert rst_n mid-PRESS -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pb_cmd_ctrl.sv
// Push-button gesture controller: synchronizes and debounces the active-low button,
// classifies SHORT / LONG / DOUBLE gestures and hands them out through cmd_vld/cmd_ack.
module pb_cmd_ctrl #(
  parameter int DB_CNT   = 500000,
  parameter int LONG_CNT = 50000000,
  parameter int DBL_WIN  = 15000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PB,
  input  logic       cmd_ack,
  output logic       pressed,
  output logic [1:0] cmd,
  output logic       cmd_vld,
  output logic       overrun
);
  localparam int TMAX = (LONG_CNT > DBL_WIN) ? LONG_CNT : DBL_WIN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(DB_CNT + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CNT - 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CNT - 1);
  localparam logic [TW-1:0] DBL_LAST  = TW'(DBL_WIN - 1);
  localparam logic [1:0] CMD_SHORT  = 2'b01;
  localparam logic [1:0] CMD_LONG   = 2'b10;
  localparam logic [1:0] CMD_DOUBLE = 2'b11;

  typedef enum logic [2:0] {IDLE, PRESS, HOLD, WAIT2, PRESS2} state_t;

  logic          sync_p0, sync_p1, stable_p2;
  logic [DW-1:0] db_cnt;
  logic          db_flip, press_evt, rel_evt;
  state_t        state;
  logic [TW-1:0] timer;
  logic          emit;
  logic [1:0]    emit_cmd;

  // Stage 0/1: two-flop synchronizer, preset so reset release reads as idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= PB;
      sync_p1 <= sync_p0;
    end
  end

  // Decoded in the cycle before stable_p2 flips, so the FSM moves on that same edge
  assign db_flip   = (sync_p1 != stable_p2) && (db_cnt == DB_LAST);
  assign press_evt = db_flip && stable_p2;
  assign rel_evt   = db_flip && !stable_p2;
  assign pressed   = ~stable_p2;

  // Stage 2: debounce; any return to the stable level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p2 <= 1'b1;
      db_cnt    <= '0;
    end else if (sync_p1 == stable_p2) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable_p2 <= sync_p1;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_comb begin
    emit     = 1'b0;
    emit_cmd = CMD_SHORT;
    case (state)
      PRESS:  if (!rel_evt && timer == LONG_LAST) begin
                emit     = 1'b1;
                emit_cmd = CMD_LONG;
              end
      WAIT2:  if (!press_evt && timer == DBL_LAST) begin
                emit     = 1'b1;
                emit_cmd = CMD_SHORT;
              end
      PRESS2: if (rel_evt) begin
                emit     = 1'b1;
                emit_cmd = CMD_DOUBLE;
              end
      default: ;
    endcase
  end

  // Stage 3: gesture FSM and single-entry command register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      cmd     <= 2'b00;
      cmd_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (press_evt) state <= PRESS;
        end
        PRESS: begin
          if (rel_evt) begin
            state <= WAIT2;
            timer <= '0;
          end else if (emit) begin
            state <= HOLD;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD: begin
          timer <= '0;
          if (rel_evt) state <= IDLE;
        end
        WAIT2: begin
          if (press_evt) begin
            state <= PRESS2;
            timer <= '0;
          end else if (emit) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PRESS2: begin
          timer <= '0;
          if (rel_evt) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase

      // A same-cycle ack frees the slot, so the new event replaces the old one
      if (emit) begin
        if (!cmd_vld || cmd_ack) begin
          cmd     <= emit_cmd;
          cmd_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (cmd_ack) begin
        cmd_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pb_cmd_ctrl.sv
// Bench for pb_cmd_ctrl with DB_CNT=4, LONG_CNT=20, DBL_WIN=10: a table of button
// waveforms with hand-computed edge numbers, plus handshake/overrun/reset sequences.
module tb_pb_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       PB;
  logic       cmd_ack;
  logic       pressed;
  logic [1:0] cmd;
  logic       cmd_vld;
  logic       overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pb_cmd_ctrl #(.DB_CNT(4), .LONG_CNT(20), .DBL_WIN(10)) dut (
    .clk(clk), .rst_n(rst_n), .PB(PB), .cmd_ack(cmd_ack),
    .pressed(pressed), .cmd(cmd), .cmd_vld(cmd_vld), .overrun(overrun)
  );

  // PB is low on edges 1..l1 and (if l2>0) on the l2 edges after a gap of 'gap' edges.
  // exp_pr / exp_vl: first edge after reset release where pressed / cmd_vld is 1 (0 = never).
  typedef struct {
    int         l1;
    int         gap;
    int         l2;
    int         exp_pr;
    int         exp_vl;
    logic [1:0] exp_cmd;
    logic       exp_ovr;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string what, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", what, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    PB      = 1'b1;
    cmd_ack = 1'b0;
    tick();
    tick();
    check("reset pressed", int'(pressed), 0);
    check("reset cmd", int'(cmd), 0);
    check("reset cmd_vld", int'(cmd_vld), 0);
    check("reset overrun", int'(overrun), 0);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t       v;
    int         pr;
    int         vl;
    logic [1:0] c_at;
    bit         low;
    v = vecs[i];
    do_reset();
    pr   = 0;
    vl   = 0;
    c_at = 2'b00;
    for (int e = 1; e <= 100; e++) begin
      low = (e <= v.l1) ||
            (v.l2 > 0 && e > v.l1 + v.gap && e <= v.l1 + v.gap + v.l2);
      PB = !low;
      tick();
      if (pressed && pr == 0) pr = e;
      if (cmd_vld && vl == 0) begin
        vl   = e;
        c_at = cmd;
      end
    end
    check($sformatf("v%0d pressed_edge", i), pr, v.exp_pr);
    check($sformatf("v%0d vld_edge", i), vl, v.exp_vl);
    check($sformatf("v%0d cmd_at_vld", i), int'(c_at), int'(v.exp_cmd));
    check($sformatf("v%0d cmd_final", i), int'(cmd), int'(v.exp_cmd));
    check($sformatf("v%0d overrun", i), int'(overrun), int'(v.exp_ovr));
    check($sformatf("v%0d pressed_final", i), int'(pressed), 0);
    if (v.exp_vl != 0) begin
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      check($sformatf("v%0d vld_after_ack", i), int'(cmd_vld), 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    PB      = 1'b1;
    cmd_ack = 1'b0;

    //         l1  gap l2  pr  vl  cmd    ovr
    vecs[0]  = '{0,  0,  0,  0,  0, 2'b00, 1'b0}; // idle for 100 cycles
    vecs[1]  = '{3,  0,  0,  0,  0, 2'b00, 1'b0}; // 3-cycle glitch
    vecs[2]  = '{12, 0,  0,  6, 28, 2'b01, 1'b0}; // short: WAIT2 at 18
    vecs[3]  = '{40, 0,  0,  6, 26, 2'b10, 1'b0}; // long, release in HOLD is silent
    vecs[4]  = '{8,  6,  8,  6, 28, 2'b11, 1'b0}; // double
    vecs[5]  = '{4,  0,  0,  6, 20, 2'b01, 1'b0}; // shortest accepted press
    vecs[6]  = '{19, 0,  0,  6, 35, 2'b01, 1'b0}; // release one edge before threshold
    vecs[7]  = '{20, 0,  0,  6, 36, 2'b01, 1'b0}; // release and threshold same edge
    vecs[8]  = '{21, 0,  0,  6, 26, 2'b10, 1'b0}; // threshold one edge before release
    vecs[9]  = '{4, 10,  4,  6, 24, 2'b11, 1'b0}; // second press on the timeout edge
    vecs[10] = '{4, 11,  4,  6, 20, 2'b01, 1'b1}; // second press just late: two shorts
    vecs[11] = '{3,  1,  4, 10, 24, 2'b01, 1'b0}; // bounce restarts the debounce

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Unacknowledged SHORT, then a LONG that must be dropped
    do_reset();
    PB = 1'b0; repeat (12) tick();
    PB = 1'b1; repeat (18) tick();
    check("A short pending vld", int'(cmd_vld), 1);
    check("A short pending cmd", int'(cmd), 1);
    PB = 1'b0; repeat (30) tick();
    check("A dropped long cmd", int'(cmd), 1);
    check("A dropped long vld", int'(cmd_vld), 1);
    check("A overrun set", int'(overrun), 1);
    PB = 1'b1; repeat (10) tick();
    check("A released", int'(pressed), 0);
    check("A overrun sticky", int'(overrun), 1);

    // Asynchronous reset while in PRESS discards everything at once
    PB = 1'b0; repeat (8) tick();
    check("D pressed before reset", int'(pressed), 1);
    #2 rst_n = 1'b0;
    #1;
    check("D async pressed", int'(pressed), 0);
    check("D async cmd", int'(cmd), 0);
    check("D async cmd_vld", int'(cmd_vld), 0);
    check("D async overrun", int'(overrun), 0);
    PB = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Pending SHORT replaced by a LONG whose emit edge carries cmd_ack
    PB = 1'b0; repeat (12) tick();
    PB = 1'b1; repeat (18) tick();
    check("B short pending cmd", int'(cmd), 1);
    PB = 1'b0; repeat (25) tick();
    check("B before emit vld", int'(cmd_vld), 1);
    check("B before emit cmd", int'(cmd), 1);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    check("B ack+emit cmd", int'(cmd), 2);
    check("B ack+emit vld", int'(cmd_vld), 1);
    check("B ack+emit overrun", int'(overrun), 0);
    PB = 1'b1; repeat (12) tick();
    check("B hold release cmd", int'(cmd), 2);
    check("B hold release vld", int'(cmd_vld), 1);
    check("B hold release overrun", int'(overrun), 0);

    // Ack consumes; ack with nothing pending is ignored
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    check("C ack clears vld", int'(cmd_vld), 0);
    cmd_ack = 1'b1;
    tick();
    tick();
    cmd_ack = 1'b0;
    tick();
    check("C idle ack vld", int'(cmd_vld), 0);
    check("C idle ack cmd", int'(cmd), 2);
    check("C idle ack overrun", int'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
